// File: rtl/mem_port_arbiter.sv
// N-channel arbiter merging mp-style read/write/resp requesters onto one memory port.
// Round-robin or fixed-priority selection; one transaction in flight at a time.
module mem_port_arbiter #(
    parameter  int NUM_CH  = 2,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int RR_MODE = 1,
    localparam int GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    input  logic [NUM_CH*BE_W-1:0]   ch_byte_enable,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [BE_W-1:0]          mem_byte_enable,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic [GW-1:0]            grant_idx,
    output logic                     busy
);

    // Handshake: a channel holds read/write (and its address/data) until it sees
    // its ch_resp pulse, then drops the request the following cycle. The memory
    // side sees mem_read/mem_write held until a single-cycle mem_resp.
    typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_CH-1:0]   req;
    logic                any_req;
    logic [GW-1:0]       winner;
    logic [GW-1:0]       rr_ptr;
    logic [ADDR_W-1:0]   addr_a [NUM_CH];
    logic [DATA_W-1:0]   wdata_a [NUM_CH];
    logic [BE_W-1:0]     be_a [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_a[i]  = ch_address[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = ch_wdata[i*DATA_W +: DATA_W];
        assign be_a[i]    = ch_byte_enable[i*BE_W +: BE_W];
    end

    assign req     = ch_read | ch_write;
    assign any_req = |req;

    // Scan candidates starting at the RR pointer (or at 0 for fixed priority).
    always_comb begin
        logic [GW:0] cand;
        logic        found;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (RR_MODE != 0) ? ({1'b0, rr_ptr} + (GW+1)'(k)) : (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_CH)) begin
                cand = cand - (GW+1)'(NUM_CH);
            end
            if (!found && req[cand[GW-1:0]]) begin
                found  = 1'b1;
                winner = cand[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (mem_resp) state_next = TURN;
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            grant_idx       <= '0;
            rr_ptr          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx       <= winner;
                        mem_address     <= addr_a[winner];
                        mem_wdata       <= wdata_a[winner];
                        mem_byte_enable <= be_a[winner];
                        // Read and write together is a write.
                        mem_write       <= ch_write[winner];
                        mem_read        <= ch_read[winner] & ~ch_write[winner];
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (RR_MODE != 0) begin
                            rr_ptr <= (grant_idx == GW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ch_resp = '0;
        if (state == BUSY && mem_resp) begin
            ch_resp[grant_idx] = 1'b1;
        end
    end

    assign ch_rdata = mem_rdata;
    assign busy     = (state == BUSY);

endmodule
